// File: rtl/switching_block.sv
// One node of a DEM DAC tree encoder: splits x_in_i into two registered
// sub-codes offset by a PN-signed switching sequence, each saturated to WIDTH.
module switching_block #(
    parameter int WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic signed [WIDTH-1:0] x_in_i,
    input  logic                    pn_seq_i,
    input  logic signed [WIDTH-1:0] quantized_value_i,
    output logic signed [WIDTH-1:0] x_out1_o,
    output logic signed [WIDTH-1:0] x_out2_o
);

    localparam int IW = WIDTH + 2;
    localparam logic signed [IW-1:0] MAXV = IW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [IW-1:0] MINV = -MAXV - IW'(1);

    logic signed [IW-1:0]    x_ext;
    logic signed [IW-1:0]    q_ext;
    logic signed [IW-1:0]    s;
    logic signed [IW-1:0]    sum;
    logic signed [IW-1:0]    a;
    logic signed [IW-1:0]    b;
    logic signed [WIDTH-1:0] x_out1_d, x_out1_q;
    logic signed [WIDTH-1:0] x_out2_d, x_out2_q;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] c;
        if (v > MAXV)
            c = MAXV;
        else if (v < MINV)
            c = MINV;
        else
            c = v;
        return c[WIDTH-1:0];
    endfunction

    // Two guard bits keep -q of the most negative code and x+s exact.
    always_comb begin
        x_ext    = {{2{x_in_i[WIDTH-1]}}, x_in_i};
        q_ext    = {{2{quantized_value_i[WIDTH-1]}}, quantized_value_i};
        s        = pn_seq_i ? q_ext : -q_ext;
        sum      = x_ext + s;
        a        = sum >>> 1;
        b        = x_ext - a;
        x_out1_d = sat(a);
        x_out2_d = sat(b);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_out1_q <= '0;
            x_out2_q <= '0;
        end else begin
            x_out1_q <= x_out1_d;
            x_out2_q <= x_out2_d;
        end
    end

    assign x_out1_o = x_out1_q;
    assign x_out2_o = x_out2_q;

endmodule

// File: tb/tb_switching_block.sv
// Scoreboard bench for switching_block: expected pairs are queued when inputs
// are driven and checked one rising edge later.
module tb_switching_block;

    typedef struct {
        int    e1;
        int    e2;
        string name;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] x_in;
    logic              pn;
    logic signed [7:0] qv;
    logic signed [7:0] out1;
    logic signed [7:0] out2;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    switching_block #(.WIDTH(8)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .x_in_i            (x_in),
        .pn_seq_i          (pn),
        .quantized_value_i (qv),
        .x_out1_o          (out1),
        .x_out2_o          (out2)
    );

    always #5 clk = ~clk;

    function automatic int clamp8(int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference: floor-halving of x + (+/-q), remainder to the lower branch.
    function automatic exp_t model(int x, int q, bit p, string name);
        exp_t r;
        int s, sum, a, b;
        s      = p ? q : -q;
        sum    = x + s;
        a      = (sum >= 0) ? sum / 2 : (sum - 1) / 2;
        b      = x - a;
        r.e1   = clamp8(a);
        r.e2   = clamp8(b);
        r.name = name;
        return r;
    endfunction

    task automatic drive(int x, int q, bit p, int e1, int e2, string name);
        exp_t r;
        x_in   = 8'(x);
        qv     = 8'(q);
        pn     = p;
        r.e1   = e1;
        r.e2   = e2;
        r.name = name;
        sb.push_back(r);
    endtask

    task automatic test_reset();
        exp_t r;
        reset = 1'b1;
        x_in  = 8'sd5;
        qv    = 8'sd3;
        pn    = 1'b1;
        #1;
        vectors++;
        if (out1 !== 8'sd0 || out2 !== 8'sd0) begin
            miscompares++;
            $display("FAIL reset_async: got (%0d,%0d) want (0,0)", out1, out2);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (out1 !== 8'sd0 || out2 !== 8'sd0) begin
            miscompares++;
            $display("FAIL reset_held: got (%0d,%0d) want (0,0)", out1, out2);
        end
        reset = 1'b0;
        drive(5, 3, 1'b1, 4, 1, "reset_release");
        @(posedge clk);
        #1;
        r = sb.pop_front();
        vectors++;
        if (out1 !== 8'(r.e1) || out2 !== 8'(r.e2)) begin
            miscompares++;
            $display("FAIL %s: got (%0d,%0d) want (%0d,%0d)", r.name, out1, out2, r.e1, r.e2);
        end
    endtask

    task automatic test_table();
        int tx[11]  = '{-3, -5, 4, 6, 7, 9, 10, 12, 127, -128, 127};
        int tq[11]  = '{0, 0, 4, 6, 7, 2, 1, 3, -128, -128, 127};
        bit tp[11]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        int te1[11] = '{-2, -3, 4, 0, 7, 3, 5, 4, -1, 0, 127};
        int te2[11] = '{-1, -2, 0, 6, 0, 6, 5, 8, 127, -128, 0};
        exp_t r;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tx[i], tq[i], tp[i], te1[i], te2[i], $sformatf("table%0d", i));
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL table_sb_empty: got 0 entries want 1");
            end else begin
                r = sb.pop_front();
                vectors++;
                if (out1 !== 8'(r.e1) || out2 !== 8'(r.e2)) begin
                    miscompares++;
                    $display("FAIL %s: got (%0d,%0d) want (%0d,%0d)", r.name, out1, out2, r.e1, r.e2);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t r;
        int   prev1 = out1;
        int   prev2 = out2;
        int   x, q;
        bit   p;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20) begin
                x = 0; q = 0; p = 1'b0;
            end else if (i == 21) begin
                x = 0; q = 0; p = 1'b1;
            end else begin
                x = $urandom_range(255) - 128;
                q = $urandom_range(255) - 128;
                p = i[0];
            end
            r = model(x, q, p, $sformatf("stream%0d", i));
            drive(x, q, p, r.e1, r.e2, r.name);
            #1;
            vectors++;
            if (out1 !== 8'(prev1) || out2 !== 8'(prev2)) begin
                miscompares++;
                $display("FAIL early_update%0d: got (%0d,%0d) want (%0d,%0d)", i, out1, out2, prev1, prev2);
            end
            @(posedge clk);
            #1;
            r = sb.pop_front();
            vectors++;
            if (out1 !== 8'(r.e1) || out2 !== 8'(r.e2)) begin
                miscompares++;
                $display("FAIL %s: got (%0d,%0d) want (%0d,%0d)", r.name, out1, out2, r.e1, r.e2);
            end
            prev1 = r.e1;
            prev2 = r.e2;
        end
    endtask

    task automatic test_midrun_reset();
        exp_t r;
        @(negedge clk);
        drive(30, 10, 1'b1, 20, 10, "pre_reset");
        @(posedge clk);
        #1;
        r = sb.pop_front();
        vectors++;
        if (out1 !== 8'(r.e1) || out2 !== 8'(r.e2)) begin
            miscompares++;
            $display("FAIL %s: got (%0d,%0d) want (%0d,%0d)", r.name, out1, out2, r.e1, r.e2);
        end
        #2;
        reset = 1'b1;
        x_in  = 8'sd20;
        qv    = 8'sd5;
        pn    = 1'b1;
        #1;
        vectors++;
        if (out1 !== 8'sd0 || out2 !== 8'sd0) begin
            miscompares++;
            $display("FAIL midrun_async: got (%0d,%0d) want (0,0)", out1, out2);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out1 !== 8'sd0 || out2 !== 8'sd0) begin
            miscompares++;
            $display("FAIL midrun_held: got (%0d,%0d) want (0,0)", out1, out2);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(20, 5, 1'b1, 12, 8, "post_reset");
        @(posedge clk);
        #1;
        r = sb.pop_front();
        vectors++;
        if (out1 !== 8'(r.e1) || out2 !== 8'(r.e2)) begin
            miscompares++;
            $display("FAIL %s: got (%0d,%0d) want (%0d,%0d)", r.name, out1, out2, r.e1, r.e2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_table();
        test_back_to_back();
        test_midrun_reset();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/switching_block.md
Name: switching_block

Overview:
- One binary-tree node of a dynamic-element-matching (DEM) DAC encoder.
- Splits a signed input code x_in_i into two signed sub-codes whose sum equals x_in_i; each sub-code feeds the next tree level or a unit-element group.
- The split offset (switching sequence) comes from the node's noise-shaping quantizer value, with its sign randomised by a PN bit.
- Outputs are registered.

Parameters:
- WIDTH, 8, signed two's-complement width of x_in_i, quantized_value_i, x_out1_o and x_out2_o.

Ports:
- clk_i  input  1  rising-edge clock
- reset_i  input  1  reset, asynchronous, active-high
- x_in_i  input  WIDTH  signed input code to be split
- pn_seq_i  input  1  pseudorandom sign bit; 1 selects +q, 0 selects -q
- quantized_value_i  input  WIDTH  signed switching-sequence magnitude q from the node quantizer
- x_out1_o  output  WIDTH  signed upper-branch code, registered
- x_out2_o  output  WIDTH  signed lower-branch code, registered

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is asynchronous and active-high.
- Reset: while reset_i=1, x_out1_o=0 and x_out2_o=0 immediately, with no clock edge needed. The first capture after release is the first rising edge with reset_i=0.
- All internal arithmetic is signed at WIDTH+2 bits, so no intermediate overflow occurs.
- Switching sequence s = pn_seq_i ? +q : -q, where q = quantized_value_i sign-extended. s = -(-2^(WIDTH-1)) is representable internally.
- sum = x_in_i + s.
- a = sum >>> 1, an arithmetic shift (floor division by 2; e.g. -3 gives -2).
- b = x_in_i - a. Hence a + b = x_in_i exactly before saturation, and b - a equals 0 or 1 minus s depending on parity.
- Saturation: a and b are each clamped independently to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. When clamping occurs, the sum-conservation property is not guaranteed; no flag is raised.
- Registration: at each rising clk_i with reset_i=0, x_out1_o <= sat(a) and x_out2_o <= sat(b).
- Latency: exactly 1 cycle from input sampling edge to output. Inputs must be stable around the rising edge; there is no handshake, and the block accepts one sample per cycle.
- Reset mid-operation: outputs are forced to 0 asynchronously. After deassertion, processing resumes on the next edge from the current inputs; no history is kept.
- Combinational only apart from the two output registers; no state machine.
- q = 0 gives a plain half split:
  - x odd: x_out1_o = floor(x/2), x_out2_o = ceil(x/2).
  - x even: both outputs equal x/2.
- Outputs are never X after reset, including when pn_seq_i toggles every cycle.

Test Plan:
- Reset: hold reset_i=1 with arbitrary inputs (x=5, q=3, pn=1) → both outputs 0 with no clock edge needed; release → next edge gives x_out1_o=4, x_out2_o=1.
- Zero-q odd negative split: x=-3, q=0, pn=1 → (-2, -1); x=-5, q=0, pn=0 → (-3, -2); the sum is conserved in both cases.
- PN sign selection:
  - x=4, q=4, pn=1 → (4, 0).
  - x=6, q=6, pn=0 → (0, 6).
  - x=7, q=7, pn=1 → (7, 0).
  - x=9, q=2, pn=0 → (3, 6).
  - x=10, q=1, pn=1 → (5, 5).
  - x=12, q=3, pn=0 → (4, 8).
- Latency: change inputs every cycle and check that each output pair appears exactly one rising edge after its inputs were sampled. Zero input (x=0, q=0, either pn) → (0, 0).
- Saturation (WIDTH=8):
  - x=127, q=-128, pn=1 → x_out1_o=-1, x_out2_o clamped to 127.
  - x=-128, q=-128, pn=0 → (0, -128).
  - x=127, q=127, pn=1 → (127, 0).
- Mid-run reset: assert reset_i between clock edges during streaming → outputs go to 0 immediately and stay 0 until the first edge after release, then track the inputs again.
